// File: rtl/uart_byte_tx_if.sv
// Handshake and serial-line bundle between the image sender (master) and uart_byte_tx (slave).
interface uart_byte_tx_if;
  logic [7:0] tx_data;
  logic       txEn;
  logic       txStart;
  logic       txBusy;
  logic       txDone;
  logic       uart_tx;

  modport master (output tx_data, txEn, txStart, input txBusy, txDone, uart_tx);
  modport slave  (input tx_data, txEn, txStart, output txBusy, txDone, uart_tx);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter, LSB first, with an internal baud counter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input logic           clk,
  input logic           rst,
  uart_byte_tx_if.slave tx_if
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             uart_tx_q, uart_tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_if.txEn && tx_if.txStart) begin
          state_d = START;
          shift_d = tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_if.tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line and busy are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    uart_tx_d = 1'b1;
    unique case (state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  uart_tx_d = par_d;
`endif
      default: uart_tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx_if.uart_tx = uart_tx_q;
  assign tx_if.txBusy  = busy_q;
  assign tx_if.txDone  = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: random requests, frame-level reference model, line monitor.
module tb_uart_byte_tx;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  uart_byte_tx_if tx_if ();

  uart_byte_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .tx_if(tx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_free = 0;
  int   stray_cnt = 0;
  int   overlap_cnt = 0;
  logic mon_active = 1'b0;
  logic pending_done = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  // Reference: accept whenever the model's previous frame (plus its done cycle) has elapsed.
  task automatic req(input logic [7:0] d, input logic en, input logic st, input int n);
    tx_if.tx_data = d;
    tx_if.txEn    = en;
    tx_if.txStart = st;
    for (int k = 0; k < n; k++) begin
      if (en && st && cyc >= model_free) begin
        exp_q.push_back('{data: d, start: cyc + 1});
        model_free = cyc + 1 + FRAME;
      end
      @(posedge clk);
      #1;
    end
    tx_if.txEn    = 1'b0;
    tx_if.txStart = 1'b0;
    tx_if.tx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_free();
    while (cyc < model_free) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: rebuilds each frame from the line and compares with the scoreboard head.
  initial begin
    exp_t       e;
    logic       exp_line[NB];
    int         idx;
    int         line_bad;
    int         busy_bad;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active   = 1'b0;
        pending_done = 1'b0;
      end else begin
        if (tx_if.txDone === 1'b1 && tx_if.txBusy === 1'b1) overlap_cnt++;
        if (pending_done) begin
          chk("done_pulse", 32'(tx_if.txDone), 32'd1);
          chk("busy_drop", 32'(tx_if.txBusy), 32'd0);
          pending_done = 1'b0;
        end else if (tx_if.txDone === 1'b1) begin
          stray_cnt++;
        end
        if (!mon_active) begin
          if (tx_if.uart_tx === 1'b0) begin
            if (exp_q.size() == 0) begin
              stray_cnt++;
              $display("FAIL spurious_frame actual=start_bit required=idle cyc=%0d", cyc);
            end else begin
              e = exp_q.pop_front();
              chk("frame_start_cyc", 32'(cyc), 32'(e.start));
              exp_line[0] = 1'b0;
              for (int i = 0; i < 8; i++) exp_line[1 + i] = e.data[i];
`ifdef UART_TX_PARITY_EN
              exp_line[9] = ^e.data;
`endif
              exp_line[NB - 1] = 1'b1;
              mon_active = 1'b1;
              idx = 0;
              line_bad = 0;
              busy_bad = 0;
              rx = '0;
            end
          end else if (tx_if.txBusy !== 1'b0) begin
            stray_cnt++;
          end
        end
        if (mon_active) begin
          if (tx_if.uart_tx !== exp_line[idx / C]) line_bad++;
          if (tx_if.txBusy !== 1'b1) busy_bad++;
          if ((idx % C) == (C / 2) && (idx / C) >= 1 && (idx / C) <= 8)
            rx[(idx / C) - 1] = tx_if.uart_tx;
          idx++;
          if (idx == FRAME) begin
            chk("frame_data", 32'(rx), 32'(e.data));
            chk("line_wave_bad_cycles", 32'(line_bad), 32'd0);
            chk("busy_in_frame_bad_cycles", 32'(busy_bad), 32'd0);
            mon_active   = 1'b0;
            pending_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    logic [7:0] rgb[3];
    rgb[0] = 8'h10;
    rgb[1] = 8'h20;
    rgb[2] = 8'h30;
    tx_if.tx_data = '0;
    tx_if.txEn    = 1'b0;
    tx_if.txStart = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk("reset_uart_tx", 32'(tx_if.uart_tx), 32'd1);
    chk("reset_busy", 32'(tx_if.txBusy), 32'd0);
    chk("reset_done", 32'(tx_if.txDone), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_line_after_reset", 32'(tx_if.uart_tx), 32'd1);

    // single byte
    req(8'hA5, 1'b1, 1'b1, 1);
    idle(FRAME + 3);

    // txStart without txEn
    req(8'h77, 1'b0, 1'b1, 20);
    chk("gated_busy", 32'(tx_if.txBusy), 32'd0);

    // request while busy is dropped
    req(8'h3C, 1'b1, 1'b1, 1);
    idle(10);
    req(8'hFF, 1'b1, 1'b1, 1);
    wait_free();
    idle(3);

    // txStart held high after accept does not retrigger
    req(8'hC3, 1'b1, 1'b1, 15);
    wait_free();
    idle(3);

    // back-to-back R,G,B issued in each done cycle
    for (int i = 0; i < 3; i++) begin
      wait_free();
      req(rgb[i], 1'b1, 1'b1, 1);
    end
    wait_free();
    idle(3);

    // reset mid-frame abandons the frame
    req(8'h5A, 1'b1, 1'b1, 1);
    idle(12);
    #1 rst = 1'b1;
    #1;
    chk("midreset_uart_tx", 32'(tx_if.uart_tx), 32'd1);
    chk("midreset_busy", 32'(tx_if.txBusy), 32'd0);
    chk("midreset_done", 32'(tx_if.txDone), 32'd0);
    exp_q.delete();
    model_free = 0;
    idle(2);
    #1 rst = 1'b0;
    idle(FRAME);
    chk("line_after_midreset", 32'(tx_if.uart_tx), 32'd1);

`ifdef UART_TX_PARITY_EN
    req(8'h07, 1'b1, 1'b1, 1);
    wait_free();
`endif

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) wait_free();
      req(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(1, 3)));
      idle(int'($urandom_range(0, 50)));
    end

    budget = 0;
    while ((exp_q.size() != 0 || mon_active || pending_done) && budget < 2 * FRAME + 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    idle(2);
    chk("drain_timeout", 32'(budget >= 2 * FRAME + 20), 32'd0);
    chk("pending_expected_frames", 32'(exp_q.size()), 32'd0);
    chk("stray_events", 32'(stray_cnt), 32'd0);
    chk("done_busy_overlap", 32'(overlap_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Serial transmit stage directly downstream of the image sender.
- Consumes one byte per tx_data/txEn/txStart handshake and shifts it out on the FPGA UART TX pin as 8N1, LSB first.
- Reports txBusy/txDone back to the sender, which paces R, G, B bytes per pixel.
- Contains its own baud-tick counter; no external baud enable.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tx_data  input  8  byte to send; sampled only on accept
- txEn  input  1  transmit enable; qualifies txStart
- txStart  input  1  start request
- txBusy  output  1  frame in progress (registered)
- txDone  output  1  one-cycle pulse at end of stop bit (registered)
- uart_tx  output  1  serial line, idle high (registered)

Behaviour:
- Reset (async assert, sync release): state IDLE, uart_tx=1, txBusy=0, txDone=0, baud counter=0, bit index=0, shift register=0.
- Accept rule: accept in cycle T when txEn & txStart & state==IDLE. tx_data is latched into the shift register in cycle T.
- txStart without txEn is ignored. Requests while busy are ignored, not queued.
- Holding txStart high after accept does not retrigger; it is re-sampled only in IDLE.
- States and transitions:
  - IDLE: uart_tx=1; on accept go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; bit index counts 0..7; after bit 7 go to PARITY (feature on) or STOP.
  - PARITY: feature only; see Optional Feature.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. Clears on accept and on every bit boundary; no wrap overrun.
- Timing, with C = CLKS_PER_BIT:
  - uart_tx falls at T+1.
  - Each bit lasts exactly C cycles.
  - Frame = 10*C cycles (11*C with parity).
- txBusy: 1 from T+1 through the last stop-bit cycle; 0 in IDLE.
- txDone: high for exactly the first IDLE cycle after STOP, i.e. the cycle txBusy drops. Never high together with txBusy.
- Back-to-back: a new accept is allowed in the same cycle txDone is high. The next start bit then begins the cycle after, giving zero idle gap between frames.
- Reset mid-frame: outputs return to reset values immediately; the partial frame is abandoned and uart_tx goes high.
- tx_data changes after accept have no effect on the frame in flight.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 latched data bits) for C cycles. Frame = 11*C; txBusy/txDone timing stretches accordingly.
- Undefined: no PARITY state; 8N1 framing, 10*C cycles.
- Host-side decoder must match the build.

Test Plan:
- Reset: assert rst mid-stream with C=4 -> uart_tx=1, txBusy=0, txDone=0 asynchronously; no glitch low after release.
- Single byte 0xA5, C=4, txEn=txStart=1 for one cycle at T:
  - Line at T+1..T+40: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), 4 cycles each.
  - txBusy high T+1..T+40; txDone pulse at T+41.
- Gating: txStart=1 with txEn=0 for 20 cycles -> no frame, txBusy stays 0.
- Busy ignore: during a 0x3C frame, pulse txEn&txStart with 0xFF -> line shows only 0x3C; no second frame.
- Back-to-back R,G,B = 0x10,0x20,0x30, next request issued in each txDone cycle -> three contiguous 40-cycle frames, no idle gap, three txDone pulses.
- UART_TX_PARITY_EN, byte 0x07, C=4 -> parity bit 1 at cycles T+37..T+40, stop at T+41..T+44, txDone at T+45.
